modadd_seq_ctrl: RTL and testbench
==================================

# modadd_seq_ctrl

Clocked sequencer for the mod-11 adder/subtractor datapath (first stage plus downstream stages). On `start` it drives all 2·M·M operand/op-select vectors (242 for M=11) through a 4-phase req/ack handshake. It compares each returned residue against an internal golden model and counts passes and failures. It sits between the test/config bus and the datapath's operand inputs.

## Interface
- `MODULUS`, 11: modulus M; operands range 0..M-1.
- `WIDTH`, 4: operand/result width; must satisfy 2^WIDTH ≥ M.
- `TIMEOUT`, 15: maximum cycles in REQ without `op_ack` before the vector is abandoned.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle pulse; honoured only in IDLE or DONE.
- `op_req`  out  1: operands valid, request to datapath.
- `op_ack`  in  1: datapath result valid.
- `s`  out  1: 0 = add, 1 = subtract.
- `x`, `y`  out  WIDTH: operands to datapath.
- `res`  in  WIDTH: datapath residue, sampled on the `op_ack` edge.
- `busy`  out  1: high in REQ, CHECK and REL.
- `done`  out  1: high in DONE; held until next `start`.
- `pass_cnt`, `fail_cnt`  out  8: result counters, saturate at 255.
- `timeout_err`  out  1: sticky; set by any timeout.
- `fail_vec`  out  1+2·WIDTH: {s,x,y} of the first failing vector.
- `fail_seen`  out  1: `fail_vec` is valid.

## Operation
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - `s`, `x`, `y` are 0.
- States:
  - IDLE → REQ on `start`. Clears counters, `timeout_err`, `fail_seen` and `fail_vec`; sets vector index to 0.
  - REQ: `op_req` = 1.
    - `op_ack` = 1 → capture `res` and go to CHECK.
    - Timer reaches TIMEOUT → fail_cnt++, set `timeout_err`, go to REL.
  - CHECK: one cycle. Compare captured `res` with the golden value.
    - Match → pass_cnt++.
    - Mismatch → fail_cnt++; if `fail_seen` = 0, latch `fail_vec` and set `fail_seen`.
    - Go to REL.
  - REL: `op_req` = 0. Wait for `op_ack` = 0.
    - If this was the last vector → DONE.
    - Otherwise advance the index → REQ.
  - DONE → REQ on `start`; re-arm exactly as from IDLE.
- Vector order:
  - Nesting is s outer, x middle, y inner.
  - Index = s·M² + x·M + y.
  - Last vector is {1, M-1, M-1}.
- Golden value, computed at WIDTH+1 bits:
  - s=0: (x+y) ≥ M ? x+y−M : x+y.
  - s=1: x ≥ y ? x−y : x−y+M.
- Operand stability: `s`, `x`, `y` change only on REQ entry and are stable while `op_req` = 1.
- `start` while busy is ignored.
- Counters saturate; they never wrap.
- An `op_ack` still high after a timeout is absorbed in REL; it never counts as a result.
- `rst_n` low mid-run aborts immediately to reset values. No partial results are retained.

## Timing
- `op_req` rises on the first edge after `start` is sampled.
- Minimum per vector with zero-wait ack: 3 cycles (REQ, CHECK, REL).
- Full run with zero-wait ack: 242·3 = 726 cycles from `start` to `done`.
- `res` is registered on the same edge on which `op_ack` = 1 is seen in REQ.
- Counter updates are visible one cycle after CHECK.
- The timeout counter resets on REQ entry. The timeout fires on the TIMEOUT-th consecutive REQ cycle with `op_ack` = 0.

## Configuration
- `MODADD_SEQ_STOP_ON_FAIL_EN`:
  - Defined: the first mismatch or timeout ends the run. After REL the block goes to DONE with `done` = 1, and no further vectors are issued.
  - Undefined: all vectors always run.
- Port list is identical in both builds.

## Structure
- Package `mod_arith_pkg` holds:
  - MODULUS and WIDTH defaults.
  - Total-vector constant 2·M².
  - The state enum.
  - Function `mod_golden(s,x,y)`.
- Sub-module `modadd_vec_gen`: holds the s/x/y nested counters, with inputs `clr` and `adv` and output `last`.
- The FSM, timer, compare and counters stay in `modadd_seq_ctrl`.

## Test plan
- Ideal datapath model with 0-cycle ack and correct results; `start` → `done` after 726 cycles, pass_cnt = 242, fail_cnt = 0, `fail_seen` = 0.
- Model that returns a wrong residue only for {s=1, x=3, y=7}, correct result 7 → fail_cnt = 1, pass_cnt = 241, fail_vec = {1,3,7}.
- Model that never acks vector {0,0,5} → REQ lasts exactly 15 cycles, `timeout_err` = 1, fail_cnt = 1, run completes.
- Random 0–5 cycle ack delays with `start` pulsed mid-run → start ignored, final pass_cnt = 242, `s`/`x`/`y` never change while `op_req` = 1.
- `rst_n` low at vector 100 → all outputs 0 next cycle; a new `start` gives pass_cnt = 242.
- `MODADD_SEQ_STOP_ON_FAIL_EN` defined, fail injected at {0,2,2} → `done` after vector index 24, pass_cnt = 24, fail_cnt = 1.

Source files
------------

// File: rtl/modadd_seq_ctrl_pkg.sv
// mod_arith_pkg: shared constants, FSM state type and golden/saturation helpers for the mod-M sequencer
package mod_arith_pkg;
   localparam int MODULUS_DEF = 11;
   localparam int WIDTH_DEF   = 4;
   localparam int NUM_VEC     = 2 * MODULUS_DEF * MODULUS_DEF;
   localparam int GW          = 16;
   typedef logic [GW-1:0] gval_t;
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_CHECK, ST_REL, ST_DONE} state_e;
   // Result is evaluated wider than WIDTH+1, so x+y and x-y+m cannot overflow.
   function automatic gval_t mod_golden(input logic s, input gval_t x, input gval_t y,
                                        input gval_t m = gval_t'(MODULUS_DEF));
      gval_t sum;
      sum = x + y;
      return s ? ((x >= y) ? x - y : x - y + m) : ((sum >= m) ? sum - m : sum);
   endfunction
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/modadd_seq_ctrl_if.sv
// modadd_seq_ctrl_if: operand/result handshake between the sequencer (master) and the datapath (slave)
interface modadd_seq_ctrl_if import mod_arith_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
   logic             op_req;
   logic             op_ack;
   logic             s;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] res;
   modport master (output op_req, s, x, y, input op_ack, res);
   modport slave  (input op_req, s, x, y, output op_ack, res);
endinterface

// File: rtl/modadd_vec_gen.sv
// modadd_vec_gen: nested s/x/y operand counters (s outer, x middle, y inner), each 0..M-1
module modadd_vec_gen import mod_arith_pkg::*; #(
   parameter int MODULUS = MODULUS_DEF,
   parameter int WIDTH   = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             adv,
   output logic             s,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             last
);
   localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
   logic             s_d, s_q;
   logic [WIDTH-1:0] x_d, x_q, y_d, y_q;
   logic             x_wrap, y_wrap;
   // next operand: clear wins over advance; carries ripple y -> x -> s
   always_comb begin
      y_wrap = y_q == TOP;
      x_wrap = x_q == TOP;
      y_d    = clr ? '0 : adv ? (y_wrap ? '0 : y_q + 1'b1) : y_q;
      x_d    = clr ? '0 : (adv && y_wrap) ? (x_wrap ? '0 : x_q + 1'b1) : x_q;
      s_d    = clr ? 1'b0 : (adv && y_wrap && x_wrap) ? ~s_q : s_q;
   end
   // operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q <= 1'b0;
         x_q <= '0;
         y_q <= '0;
      end else begin
         s_q <= s_d;
         x_q <= x_d;
         y_q <= y_d;
      end
   end
   assign s    = s_q;
   assign x    = x_q;
   assign y    = y_q;
   assign last = s_q & x_wrap & y_wrap;
endmodule

// File: rtl/modadd_seq_ctrl.sv
// modadd_seq_ctrl: drives all 2*M*M vectors through req/ack, checks residues, counts pass/fail.
// Build option MODADD_SEQ_STOP_ON_FAIL_EN: end the run after the first mismatch or timeout.
module modadd_seq_ctrl import mod_arith_pkg::*; #(
   parameter int MODULUS = MODULUS_DEF,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   modadd_seq_ctrl_if.master  bus,
   output logic               busy,
   output logic               done,
   output logic [7:0]         pass_cnt,
   output logic [7:0]         fail_cnt,
   output logic               timeout_err,
   output logic [2*WIDTH:0]   fail_vec,
   output logic               fail_seen
);
   localparam int TW = $clog2(TIMEOUT + 1);
   state_e             state_d, state_q;
   logic [TW-1:0]      tmr_d, tmr_q;
   logic [WIDTH-1:0]   res_d, res_q;
   logic [7:0]         pass_d, pass_q, fail_d, fail_q;
   logic               to_d, to_q, fseen_d, fseen_q;
   logic [2*WIDTH:0]   fvec_d, fvec_q;
   logic               clr, adv, last, vs, stop, match;
   logic [WIDTH-1:0]   vx, vy;

   modadd_vec_gen #(.MODULUS(MODULUS), .WIDTH(WIDTH)) u_vec (
      .clk(clk), .rst_n(rst_n), .clr(clr), .adv(adv),
      .s(vs), .x(vx), .y(vy), .last(last)
   );

   assign match = gval_t'(res_q) == mod_golden(vs, gval_t'(vx), gval_t'(vy), gval_t'(MODULUS));
`ifdef MODADD_SEQ_STOP_ON_FAIL_EN
   assign stop = fail_q != 8'd0;
`else
   assign stop = 1'b0;
`endif

   // FSM next state, handshake timer, result capture and counter updates
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      res_d   = res_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      to_d    = to_q;
      fseen_d = fseen_q;
      fvec_d  = fvec_q;
      clr     = 1'b0;
      adv     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: if (start) begin
            state_d = ST_REQ;
            clr     = 1'b1;
            tmr_d   = '0;
            pass_d  = '0;
            fail_d  = '0;
            to_d    = 1'b0;
            fseen_d = 1'b0;
            fvec_d  = '0;
         end
         ST_REQ: if (bus.op_ack) begin
            res_d   = bus.res;
            state_d = ST_CHECK;
         end else if (tmr_q == TW'(TIMEOUT - 1)) begin
            fail_d  = sat_inc(fail_q);
            to_d    = 1'b1;
            state_d = ST_REL;
         end else begin
            tmr_d   = tmr_q + 1'b1;
         end
         ST_CHECK: begin
            state_d = ST_REL;
            if (match) pass_d = sat_inc(pass_q);
            else begin
               fail_d = sat_inc(fail_q);
               if (!fseen_q) begin
                  fseen_d = 1'b1;
                  fvec_d  = {vs, vx, vy};
               end
            end
         end
         ST_REL: if (!bus.op_ack) begin
            if (last || stop) state_d = ST_DONE;
            else begin
               adv     = 1'b1;
               tmr_d   = '0;
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state, timer, captured residue and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         res_q   <= '0;
         pass_q  <= '0;
         fail_q  <= '0;
         to_q    <= 1'b0;
         fseen_q <= 1'b0;
         fvec_q  <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         res_q   <= res_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         to_q    <= to_d;
         fseen_q <= fseen_d;
         fvec_q  <= fvec_d;
      end
   end

   assign bus.op_req  = state_q == ST_REQ;
   assign bus.s       = vs;
   assign bus.x       = vx;
   assign bus.y       = vy;
   assign busy        = state_q inside {ST_REQ, ST_CHECK, ST_REL};
   assign done        = state_q == ST_DONE;
   assign pass_cnt    = pass_q;
   assign fail_cnt    = fail_q;
   assign timeout_err = to_q;
   assign fail_vec    = fvec_q;
   assign fail_seen   = fseen_q;
endmodule

// File: tb/tb_modadd_seq_ctrl.sv
// tb_modadd_seq_ctrl: directed bench with a behavioural mod-11 datapath and handshake monitor
module tb_modadd_seq_ctrl;
   import mod_arith_pkg::*;
`ifdef MODADD_SEQ_STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst_n, start;
   logic       busy, done, timeout_err, fail_seen;
   logic [7:0] pass_cnt, fail_cnt;
   logic [8:0] fail_vec;
   int checks = 0, failures = 0;
   int dly_max, bad_idx, noack_idx, wcnt, wdel;
   int exp_idx, ord_err, stab_err, req_len, req_vec, len5, cyc;
   logic req_prev = 1'b0;
   logic [8:0] vec_prev;

   modadd_seq_ctrl_if #(.WIDTH(4)) bus ();

   modadd_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
      .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .timeout_err(timeout_err), .fail_vec(fail_vec), .fail_seen(fail_seen)
   );

   always #5 clk = ~clk;

   function automatic int cur_idx();
      return int'(bus.s) * 121 + int'(bus.x) * 11 + int'(bus.y);
   endfunction

   function automatic int gold(int s, int x, int y);
      return s ? (x - y + 11) % 11 : (x + y) % 11;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // datapath model: ack after a delay with the true residue (optionally corrupted or withheld)
   always @(negedge clk) begin
      if (!bus.op_req) begin
         bus.op_ack = 1'b0;
         wcnt = 0;
         wdel = (dly_max == 0) ? 0 : int'($urandom_range(dly_max, 0));
      end else if (!bus.op_ack && cur_idx() != noack_idx) begin
         if (wcnt >= wdel) begin
            bus.op_ack = 1'b1;
            bus.res = 4'(gold(int'(bus.s), int'(bus.x), int'(bus.y)) ^ int'(cur_idx() == bad_idx));
         end else wcnt++;
      end
   end

   // monitor: vector order, operand stability and REQ length of vector 5
   always @(negedge clk) begin
      if (bus.op_req && !req_prev) begin
         if (cur_idx() != exp_idx) ord_err++;
         exp_idx++;
         req_len = 0;
         req_vec = cur_idx();
      end
      if (bus.op_req && req_prev && {bus.s, bus.x, bus.y} != vec_prev) stab_err++;
      if (bus.op_req) req_len++;
      if (!bus.op_req && req_prev && req_vec == 5) len5 = req_len;
      req_prev = bus.op_req;
      vec_prev = {bus.s, bus.x, bus.y};
   end

   task automatic launch();
      ord_err = 0;
      stab_err = 0;
      @(negedge clk);
      start = 1'b1;
      exp_idx = 0;
      @(negedge clk);
      start = 1'b0;
      chk("req_rise", bus.op_req, 1);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 5000) begin
         @(posedge clk);
         #1 n++;
      end
      chk("done_seen", done, 1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; bus.op_ack = 1'b0; bus.res = '0;
      dly_max = 0; bad_idx = -1; noack_idx = -1; len5 = 0; req_vec = -1;
      repeat (3) @(negedge clk);
      chk("rst_op_req", bus.op_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass_cnt, 0);
      chk("rst_fail", fail_cnt, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_fail_seen", fail_seen, 0);
      chk("rst_fail_vec", fail_vec, 0);
      chk("rst_sxy", {bus.s, bus.x, bus.y}, 0);
      rst_n = 1'b1;
      // ideal datapath
      launch();
      wait_done(cyc);
      chk("ideal_cycles", cyc, 726);
      chk("ideal_pass", pass_cnt, 242);
      chk("ideal_fail", fail_cnt, 0);
      chk("ideal_fail_seen", fail_seen, 0);
      chk("ideal_timeout", timeout_err, 0);
      chk("ideal_busy", busy, 0);
      chk("ideal_order", ord_err, 0);
      chk("ideal_stable", stab_err, 0);
      chk("ideal_last_sxy", {bus.s, bus.x, bus.y}, 9'h1aa);
      // wrong residue at {1,3,7} = index 161
      bad_idx = 161;
      launch();
      wait_done(cyc);
      chk("bad161_cycles", cyc, STOP ? 486 : 726);
      chk("bad161_pass", pass_cnt, STOP ? 161 : 241);
      chk("bad161_fail", fail_cnt, 1);
      chk("bad161_fail_seen", fail_seen, 1);
      chk("bad161_fail_vec", fail_vec, 9'h137);
      chk("bad161_timeout", timeout_err, 0);
      // no ack for {0,0,5}
      bad_idx = -1;
      noack_idx = 5;
      launch();
      wait_done(cyc);
      chk("to_req_len", len5, 15);
      chk("to_cycles", cyc, STOP ? 31 : 739);
      chk("to_flag", timeout_err, 1);
      chk("to_fail", fail_cnt, 1);
      chk("to_pass", pass_cnt, STOP ? 5 : 241);
      chk("to_fail_seen", fail_seen, 0);
      chk("to_order", ord_err, 0);
      // wrong residue at {0,2,2} = index 24
      noack_idx = -1;
      bad_idx = 24;
      launch();
      wait_done(cyc);
      chk("bad24_cycles", cyc, STOP ? 75 : 726);
      chk("bad24_pass", pass_cnt, STOP ? 24 : 241);
      chk("bad24_fail", fail_cnt, 1);
      chk("bad24_fail_vec", fail_vec, 9'h022);
      chk("bad24_timeout", timeout_err, 0);
      // random ack delays with a start pulse while busy
      bad_idx = -1;
      dly_max = 5;
      launch();
      repeat (300) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("mid_start_busy", busy, 1);
      wait_done(cyc);
      chk("rnd_pass", pass_cnt, 242);
      chk("rnd_fail", fail_cnt, 0);
      chk("rnd_order", ord_err, 0);
      chk("rnd_stable", stab_err, 0);
      // reset at vector 100
      dly_max = 0;
      launch();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bus.op_req && cur_idx() == 100) break;
      end
      chk("reach_idx100", cur_idx(), 100);
      chk("idx100_pass", pass_cnt, 100);
      rst_n = 1'b0;
      #1;
      chk("abort_op_req", bus.op_req, 0);
      chk("abort_busy", busy, 0);
      chk("abort_pass", pass_cnt, 0);
      chk("abort_sxy", {bus.s, bus.x, bus.y}, 0);
      @(posedge clk);
      #1;
      chk("abort_hold_pass", pass_cnt, 0);
      chk("abort_hold_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      launch();
      wait_done(cyc);
      chk("rerun_cycles", cyc, 726);
      chk("rerun_pass", pass_cnt, 242);
      chk("rerun_fail", fail_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
